// File: rtl/demux1to2_buf_if.sv
// Handshake bundle for demux1to2_buf: one producer stream in, two buffered lanes out.
// The slave modport is the demux; the master modport is the producer plus both cores.
interface demux1to2_buf_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sel;

    logic             A_valid;
    logic             A_ready;
    logic [WIDTH-1:0] A;
    logic [CW-1:0]    A_count;

    logic             B_valid;
    logic             B_ready;
    logic [WIDTH-1:0] B;
    logic [CW-1:0]    B_count;

    modport slave (
        input  in_valid, in_data, sel, A_ready, B_ready,
        output in_ready, A_valid, A, A_count, B_valid, B, B_count
    );

    modport master (
        output in_valid, in_data, sel, A_ready, B_ready,
        input  in_ready, A_valid, A, A_count, B_valid, B, B_count
    );
endinterface

// File: rtl/demux1to2_buf.sv
// Registered 1-to-2 demultiplexer. The producer word is steered by sel into lane A (0) or
// lane B (1); each lane is an independent circular FIFO so a stalled core never blocks the
// other lane.
module demux1to2_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic            clk,
    input logic            rst,
    demux1to2_buf_if.slave bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Lane A state
    logic [WIDTH-1:0] mem_a_q [DEPTH];
    logic [PW-1:0]    wr_a_q, rd_a_q;
    logic [CW-1:0]    cnt_a_q, cnt_a_d;

    // Lane B state
    logic [WIDTH-1:0] mem_b_q [DEPTH];
    logic [PW-1:0]    wr_b_q, rd_b_q;
    logic [CW-1:0]    cnt_b_q, cnt_b_d;

    logic ready;
    logic push_a, push_b, pop_a, pop_b;
    logic valid_a, valid_b;

    // Acceptance depends only on the selected lane's occupancy; no full-lane pass-through.
    always_comb begin
        ready   = bus.sel ? (cnt_b_q != FULL) : (cnt_a_q != FULL);
        valid_a = (cnt_a_q != '0);
        valid_b = (cnt_b_q != '0);
        push_a  = bus.in_valid && ready && !bus.sel;
        push_b  = bus.in_valid && ready && bus.sel;
        pop_a   = valid_a && bus.A_ready;
        pop_b   = valid_b && bus.B_ready;
    end

    // Output ports: heads are shown even when empty; valid alone qualifies the data.
    always_comb begin
        bus.in_ready = ready;
        bus.A_valid  = valid_a;
        bus.B_valid  = valid_b;
        bus.A        = mem_a_q[rd_a_q];
        bus.B        = mem_b_q[rd_b_q];
        bus.A_count  = cnt_a_q;
        bus.B_count  = cnt_b_q;
    end

    // Lane A next occupancy: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_a_d = cnt_a_q;
        if (push_a && !pop_a) begin
            cnt_a_d = cnt_a_q + CNT_ONE;
        end else if (pop_a && !push_a) begin
            cnt_a_d = cnt_a_q - CNT_ONE;
        end
    end

    // Lane B next occupancy.
    always_comb begin
        cnt_b_d = cnt_b_q;
        if (push_b && !pop_b) begin
            cnt_b_d = cnt_b_q + CNT_ONE;
        end else if (pop_b && !push_b) begin
            cnt_b_d = cnt_b_q - CNT_ONE;
        end
    end

    // Lane A pointers and count; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_a_q  <= '0;
            rd_a_q  <= '0;
            cnt_a_q <= '0;
        end else begin
            if (push_a) begin
                wr_a_q <= wr_a_q + PTR_ONE;
            end
            if (pop_a) begin
                rd_a_q <= rd_a_q + PTR_ONE;
            end
            cnt_a_q <= cnt_a_d;
        end
    end

    // Lane A storage; cleared on reset so the idle head reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
            end
        end else if (push_a) begin
            mem_a_q[wr_a_q] <= bus.in_data;
        end
    end

    // Lane B pointers and count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_b_q  <= '0;
            rd_b_q  <= '0;
            cnt_b_q <= '0;
        end else begin
            if (push_b) begin
                wr_b_q <= wr_b_q + PTR_ONE;
            end
            if (pop_b) begin
                rd_b_q <= rd_b_q + PTR_ONE;
            end
            cnt_b_q <= cnt_b_d;
        end
    end

    // Lane B storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_b_q[i] <= '0;
            end
        end else if (push_b) begin
            mem_b_q[wr_b_q] <= bus.in_data;
        end
    end
endmodule
